// File: rtl/fp_sort_ctrl.sv
// fp_sort_ctrl: buffers a block of N 13-bit floats (sign[12], exp[11:8], signif[7:0]),
// bubble-sorts them into descending order with one comparator (one compare per cycle),
// then streams the sorted block out largest-first.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready/in_data producer handshake (in_ready high only while loading)
//   out_valid/out_ready/out_data consumer handshake (out_valid high only while streaming out)
//   busy                      high while sorting
//   done                      one-cycle pulse after the last output handshake of a block

// fp_greaterthan: combinational a > b over the sign/magnitude float format.
// Equal operands give 0; +0 and -0 are ordered by sign like any other pair.
module fp_greaterthan (
  input  logic [12:0] a,
  input  logic [12:0] b,
  output logic        gt_c
);
  always_comb begin
    gt_c = 1'b0;
    if (a[12] != b[12]) begin
      gt_c = ~a[12];
    end else if (!a[12]) begin
      gt_c = (a[11:0] > b[11:0]);
    end else begin
      // both negative: smaller magnitude is the larger value
      gt_c = (a[11:0] < b[11:0]);
    end
  end
endmodule

module fp_sort_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [12:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] out_data,
  output logic        busy,
  output logic        done
);
  localparam int unsigned W     = 13;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] J_LAST   = IDX_W'(N - 2);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SORT = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t           state;
  logic [W-1:0]     mem [N];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] j;
  logic [IDX_W-1:0] pass;
  logic             swapped;

  logic [IDX_W-1:0] j_nxt;
  logic [IDX_W-1:0] rd_nxt;
  logic             gt;
  logic             any_swap;

  assign j_nxt    = IDX_W'(j + 1'b1);
  assign rd_nxt   = IDX_W'(rd_idx + 1'b1);
  assign any_swap = swapped | gt;

  // Single comparator: is the later element larger than the earlier one?
  fp_greaterthan u_cmp (
    .a    (mem[j_nxt]),
    .b    (mem[j]),
    .gt_c (gt)
  );

  // Sequencer: load, sort, stream out; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      wr_idx    <= '0;
      rd_idx    <= '0;
      j         <= '0;
      pass      <= '0;
      swapped   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (in_valid && in_ready) begin
            mem[wr_idx] <= in_data;
            if (wr_idx == IDX_LAST) begin
              wr_idx   <= '0;
              state    <= ST_SORT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              wr_idx <= IDX_W'(wr_idx + 1'b1);
            end
          end
        end

        ST_SORT: begin
          if (gt) begin
            mem[j]     <= mem[j_nxt];
            mem[j_nxt] <= mem[j];
            swapped    <= 1'b1;
          end
          if (j == J_LAST) begin
            j       <= '0;
            swapped <= 1'b0;
            if (!any_swap || pass == J_LAST) begin
              state     <= ST_OUT;
              pass      <= '0;
              busy      <= 1'b0;
              out_valid <= 1'b1;
              // element 0 as it stands after this cycle's possible swap
              out_data  <= (gt && j == '0) ? mem[1] : mem[0];
            end else begin
              pass <= IDX_W'(pass + 1'b1);
            end
          end else begin
            j <= j_nxt;
          end
        end

        ST_OUT: begin
          if (out_ready) begin
            if (rd_idx == IDX_LAST) begin
              state     <= ST_LOAD;
              rd_idx    <= '0;
              wr_idx    <= '0;
              j         <= '0;
              pass      <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              in_ready  <= 1'b1;
              done      <= 1'b1;
            end else begin
              rd_idx   <= rd_nxt;
              out_data <= mem[rd_nxt];
            end
          end
        end

        default: begin
          state     <= ST_LOAD;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_sort_ctrl.sv
// tb_fp_sort_ctrl: directed-vector bench for fp_sort_ctrl (N=8) with hand-computed
// expected orderings, busy-cycle counts and handshake/pulse checks.
module tb_fp_sort_ctrl;
  typedef logic [12:0] blk_t [8];

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_data;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_sort_ctrl #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load 8 values; optional one-cycle in_valid gap before each with junk data.
  task automatic load_block(input blk_t v, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = 13'h1FFF;
        step();
      end
      chk($sformatf("in_ready_load%0d", i), 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = v[i];
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Count busy cycles; exp_busy < 0 means only bound the count.
  task automatic wait_sort(input int exp_busy, input bit junk_in);
    int cnt = 0;
    if (junk_in) begin
      in_valid = 1'b1;
      in_data  = 13'h0FFF;
    end
    chk("busy_start", 32'(busy), 32'd1);
    while (busy && cnt < 200) begin
      if (in_ready !== 1'b0) chk("in_ready_sort", 32'(in_ready), 32'd0);
      step();
      cnt++;
    end
    in_valid = 1'b0;
    if (exp_busy >= 0) chk("busy_cycles", 32'(cnt), 32'(exp_busy));
    else               chk("busy_bound", 32'(cnt <= 49 && cnt >= 7), 32'd1);
    chk("out_valid_after_sort", 32'(out_valid), 32'd1);
  endtask

  // Drain 8 values; stall inserts an out_ready=0 cycle before each transfer.
  task automatic drain(input blk_t e, input bit stall);
    for (int k = 0; k < 8; k++) begin
      if (stall) begin
        out_ready = 1'b0;
        chk($sformatf("stall_data%0d", k), 32'(out_data), 32'(e[k]));
        step();
        chk($sformatf("held_data%0d", k), 32'(out_data), 32'(e[k]));
        chk($sformatf("held_in_ready%0d", k), 32'(in_ready), 32'd0);
      end
      chk($sformatf("out_valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("out_data%0d", k), 32'(out_data), 32'(e[k]));
      chk($sformatf("done_early%0d", k), 32'(done), 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("in_ready_with_done", 32'(in_ready), 32'd1);
    chk("out_valid_end", 32'(out_valid), 32'd0);
    step();
    chk("done_clear", 32'(done), 32'd0);
  endtask

  blk_t desc_v, asc_v, mix_v, mix_e, dup_v, dup_e;

  initial begin
    for (int i = 0; i < 8; i++) begin
      desc_v[i] = {1'b0, 4'(8 - i), 8'h80};
      asc_v[i]  = {1'b0, 4'(i + 1), 8'h80};
    end
    mix_v = '{13'h0280, 13'h13C0, 13'h04A0, 13'h1180,
              13'h0610, 13'h1500, 13'h01FF, 13'h1220};
    mix_e = '{13'h0610, 13'h04A0, 13'h0280, 13'h01FF,
              13'h1180, 13'h1220, 13'h13C0, 13'h1500};
    dup_v = '{13'h0300, 13'h0590, 13'h1100, 13'h0590,
              13'h07FF, 13'h05A0, 13'h0590, 13'h0120};
    dup_e = '{13'h07FF, 13'h05A0, 13'h0590, 13'h0590,
              13'h0590, 13'h0300, 13'h0120, 13'h1100};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // already descending: one pass, order unchanged
    load_block(desc_v, 1'b0);
    wait_sort(7, 1'b0);
    drain(desc_v, 1'b0);

    // ascending: full (N-1)^2 compares, output reversed
    load_block(asc_v, 1'b0);
    wait_sort(49, 1'b0);
    drain(desc_v, 1'b0);

    // mixed signs
    load_block(mix_v, 1'b0);
    wait_sort(-1, 1'b0);
    drain(mix_e, 1'b0);

    // duplicates stay adjacent
    load_block(dup_v, 1'b0);
    wait_sort(-1, 1'b0);
    drain(dup_e, 1'b0);

    // input gaps, junk in_valid during sort, output stalls
    load_block(asc_v, 1'b1);
    wait_sort(49, 1'b1);
    drain(desc_v, 1'b1);

    // reset at pass 2, j 3 (sort cycle 17)
    load_block(asc_v, 1'b0);
    for (int c = 0; c < 17; c++) step();
    chk("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    step();
    chk("midrst_done_next", 32'(done), 32'd0);
    load_block(mix_v, 1'b0);
    wait_sort(-1, 1'b0);
    drain(mix_e, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
